// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// M-op codes (funct3), sequencer state encoding and iteration count.
package ex_mdu_pkg;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   localparam int MD_ITER = 32;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // rs1 is treated as signed by every op except the fully unsigned ones
   function automatic logic is_signed_a(input logic [2:0] op);
      return !(op == MD_MULHU || op == MD_DIVU || op == MD_REMU);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return (op == MD_MUL || op == MD_MULH || op == MD_DIV || op == MD_REM);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Datapath slice of the MDU: operand magnitudes/sign flags at start, one
// shift-add or restoring-divide step per cycle, and final sign fix-up.
module mdu_iter
   import ex_mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      start_op,
   input  logic [XLEN-1:0] opv1,
   input  logic [XLEN-1:0] opv2,
   output logic [XLEN-1:0] mag1,
   output logic [XLEN-1:0] mag2,
   output logic            neg_q,
   output logic            neg_r,
   input  logic [2:0]      op,
   input  logic            sign_q,
   input  logic            sign_r,
   input  logic [XLEN-1:0] acc_hi,
   input  logic [XLEN-1:0] acc_lo,
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] nxt_hi,
   output logic [XLEN-1:0] nxt_lo,
   output logic [XLEN-1:0] fixed
);

   logic            neg1;
   logic            neg2;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] rem_sub;
   logic [2*XLEN-1:0] product;
   logic [2*XLEN-1:0] signed_prod;

   // neg_q flips the product/quotient; neg_r gives the remainder the dividend's sign
   assign neg1  = is_signed_a(start_op) & opv1[XLEN-1];
   assign neg2  = is_signed_b(start_op) & opv2[XLEN-1];
   assign mag1  = neg1 ? -opv1 : opv1;
   assign mag2  = neg2 ? -opv2 : opv2;
   assign neg_q = neg1 ^ neg2;
   assign neg_r = neg1;

   // Multiply: {acc_hi, acc_lo} shifts right with the multiplier in acc_lo.
   // Divide: acc_hi is the remainder, acc_lo shifts dividend out and quotient in;
   // the restored remainder is always below the divisor so it fits in XLEN bits.
   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
      shifted = {acc_hi, acc_lo[XLEN-1]};
      rem_sub = shifted[XLEN-1:0] - operand;
      nxt_hi  = sum[XLEN:1];
      nxt_lo  = {sum[0], acc_lo[XLEN-1:1]};
      if (op[2]) begin
         if (shifted >= {1'b0, operand}) begin
            nxt_hi = rem_sub;
            nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            nxt_hi = shifted[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
         end
      end
   end

   assign product     = {nxt_hi, nxt_lo};
   assign signed_prod = sign_q ? -product : product;

   // Fix-up is taken on the post-step accumulator so the last step can retire directly
   always_comb begin
      fixed = '0;
      case (op)
         MD_MUL:                        fixed = signed_prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  fixed = signed_prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:               fixed = sign_q ? -nxt_lo : nxt_lo;
         default:                       fixed = sign_r ? -nxt_hi : nxt_hi;
      endcase
   end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide sequencer beside the EX ALU; stalls the
// front of the pipe via stallreq until a registered result is available.
module ex_mdu
   import ex_mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] opv1,
   input  logic [XLEN-1:0] opv2,
   input  logic            flush,
   input  logic            hold,
   output logic            stallreq,
   output logic            done,
   output logic [XLEN-1:0] result
);

   md_state_e       state;
   md_state_e       state_nxt;
   logic [4:0]      cnt;
   logic [2:0]      op_q;
   logic            sign_q;
   logic            sign_r;
   logic [XLEN-1:0] acc_hi;
   logic [XLEN-1:0] acc_lo;
   logic [XLEN-1:0] operand;
   logic [XLEN-1:0] mag1;
   logic [XLEN-1:0] mag2;
   logic            neg_q;
   logic            neg_r;
   logic [XLEN-1:0] nxt_hi;
   logic [XLEN-1:0] nxt_lo;
   logic [XLEN-1:0] fixed;
   logic            start;
   logic            div_zero;
   logic            div_ovf;
   logic            special;
   logic [XLEN-1:0] special_res;

   mdu_iter #(.XLEN(XLEN)) u_iter (
      .start_op (op),
      .opv1     (opv1),
      .opv2     (opv2),
      .mag1     (mag1),
      .mag2     (mag2),
      .neg_q    (neg_q),
      .neg_r    (neg_r),
      .op       (op_q),
      .sign_q   (sign_q),
      .sign_r   (sign_r),
      .acc_hi   (acc_hi),
      .acc_lo   (acc_lo),
      .operand  (operand),
      .nxt_hi   (nxt_hi),
      .nxt_lo   (nxt_lo),
      .fixed    (fixed)
   );

   assign start    = (state == MD_IDLE) & req & ~flush;
   assign stallreq = req & ~flush & (state != MD_DONE);

   // Divide-by-zero and signed overflow bypass the loop entirely
   assign div_zero = op[2] & (opv2 == '0);
   assign div_ovf  = (op == MD_DIV || op == MD_REM) &
                     (opv1 == {1'b1, {(XLEN-1){1'b0}}}) & (opv2 == '1);
   assign special  = div_zero | div_ovf;

   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = op[1] ? opv1 : '1;
      else if (op == MD_DIV)
         special_res = {1'b1, {(XLEN-1){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= MD_IDLE;
      else
         state <= state_nxt;
   end

   // flush wins in every state and kills the op before it can report done
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = MD_IDLE;
      end else begin
         case (state)
            MD_IDLE: if (req) state_nxt = special ? MD_DONE : MD_BUSY;
            MD_BUSY: if (cnt == 5'(MD_ITER - 1)) state_nxt = MD_DONE;
            MD_DONE: if (!hold) state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         op_q    <= '0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         operand <= '0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         done <= (state_nxt == MD_DONE);
         if (flush) begin
            cnt <= '0;
         end else if (start) begin
            op_q    <= op;
            sign_q  <= neg_q;
            sign_r  <= neg_r;
            acc_hi  <= '0;
            acc_lo  <= mag1;
            operand <= mag2;
            cnt     <= '0;
            if (special)
               result <= special_res;
         end else if (state == MD_BUSY) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'(MD_ITER - 1))
               result <= fixed;
         end
      end
   end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed RV32M cases with literal results,
// flush/hold/reset scenarios, then randomized ops against an arithmetic model.
module tb_ex_mdu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] opv1 = '0;
   logic [31:0] opv2 = '0;
   logic        flush = 1'b0;
   logic        hold = 1'b0;
   logic        stallreq;
   logic        done;
   logic [31:0] result;

   int          checks = 0;
   int          errors = 0;
   int          stall_cnt = 0;
   bit          check_en = 1'b0;
   bit          exp_stall = 1'b0;
   bit          exp_done = 1'b0;
   bit          res_stable = 1'b0;
   logic [31:0] exp_result = '0;

   ex_mdu #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .op       (op),
      .opv1     (opv1),
      .opv2     (opv2),
      .flush    (flush),
      .hold     (hold),
      .stallreq (stallreq),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   // RV32M results straight from the ISA definition using 64-bit arithmetic
   function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int          sa;
      int          sb;
      sa = a;
      sb = b;
      case (o)
         3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0];  end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      return o[2] && (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: outputs versus the bench's expectation every cycle
   always @(negedge clk) begin
      if (check_en) begin
         check_output("stallreq", {31'd0, stallreq}, {31'd0, exp_stall});
         check_output("done", {31'd0, done}, {31'd0, exp_done});
         if (exp_done || res_stable)
            check_output("result", result, exp_result);
         if (stallreq)
            stall_cnt++;
      end
   end

   // Runs one op from its start cycle through the last DONE cycle; req stays high
   task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int hold_n, input bit use_lit, input logic [31:0] lit);
      int lat;
      int s0;
      lat = is_special(o, a, b) ? 1 : 33;
      @(posedge clk); #1;
      req = 1'b1; flush = 1'b0; hold = 1'b0;
      op = o; opv1 = a; opv2 = b;
      exp_stall = 1'b1; exp_done = 1'b0;
      s0 = stall_cnt;
      for (int k = 1; k < lat; k++) begin
         @(posedge clk); #1;
         if (k == 1) res_stable = 1'b0;
         op = 3'($urandom); opv1 = $urandom; opv2 = $urandom;
      end
      @(posedge clk); #1;
      res_stable = 1'b0;
      exp_stall = 1'b0; exp_done = 1'b1;
      exp_result = ref_mdu(o, a, b);
      hold = (hold_n > 0);
      @(negedge clk);
      check_output("stall_cycles", 32'(stall_cnt - s0), 32'(lat));
      if (use_lit)
         check_output("lit_result", result, lit);
      for (int k = 1; k <= hold_n; k++) begin
         @(posedge clk); #1;
         hold = (k < hold_n);
      end
   endtask

   task automatic go_idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         req = 1'b0; hold = 1'b0; flush = 1'b0;
         exp_stall = 1'b0; exp_done = 1'b0;
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("reset_done", {31'd0, done}, 32'd0);
      check_output("reset_result", result, 32'd0);
      check_output("reset_stallreq", {31'd0, stallreq}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_en = 1'b1;
      exp_result = 32'd0;
      res_stable = 1'b1;
      go_idle(2);

      apply_stimulus(3'd0, 32'd7, -32'sd3, 0, 1'b1, 32'hFFFF_FFEB);
      apply_stimulus(3'd1, 32'd7, -32'sd3, 0, 1'b1, 32'hFFFF_FFFF);
      go_idle(1);
      apply_stimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE);
      apply_stimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFF);
      apply_stimulus(3'd4, -32'sd7, 32'd2, 0, 1'b1, 32'hFFFF_FFFD);
      apply_stimulus(3'd6, -32'sd7, 32'd2, 0, 1'b1, 32'hFFFF_FFFF);
      go_idle(1);
      apply_stimulus(3'd5, 32'd100, 32'd7, 0, 1'b1, 32'd14);
      apply_stimulus(3'd7, 32'd100, 32'd7, 0, 1'b1, 32'd2);
      apply_stimulus(3'd4, 32'd5, 32'd0, 0, 1'b1, 32'hFFFF_FFFF);
      apply_stimulus(3'd6, 32'd5, 32'd0, 0, 1'b1, 32'd5);
      apply_stimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000);
      go_idle(2);

      // done/result must hold steady for 4 cycles under a 3-cycle hold
      apply_stimulus(3'd0, 32'd3, 32'd4, 3, 1'b1, 32'd12);
      go_idle(1);

      // flush in cycle 10 of a DIV; req stays high so the flush cycle must not start
      @(posedge clk); #1;
      req = 1'b1; op = 3'd4; opv1 = -32'sd100; opv2 = 32'd7;
      exp_stall = 1'b1; exp_done = 1'b0;
      for (int k = 1; k < 10; k++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      flush = 1'b1; exp_stall = 1'b0; res_stable = 1'b1;
      apply_stimulus(3'd0, 32'd3, 32'd4, 0, 1'b1, 32'd12);

      // synchronous reset in the middle of BUSY
      @(posedge clk); #1;
      req = 1'b1; op = 3'd0; opv1 = 32'd9; opv2 = 32'd9;
      exp_stall = 1'b1; exp_done = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      rst = 1'b1; req = 1'b0; exp_stall = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; exp_result = 32'd0; res_stable = 1'b1;
      @(negedge clk);
      check_output("midrst_result", result, 32'd0);
      check_output("midrst_done", {31'd0, done}, 32'd0);
      apply_stimulus(3'd0, 32'd6, 32'd7, 0, 1'b1, 32'd42);
      go_idle(1);

      for (int n = 0; n < 40; n++) begin
         apply_stimulus(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                        int'($urandom_range(0, 2)), 1'b0, 32'd0);
         go_idle(int'($urandom_range(0, 2)));
      end
      go_idle(2);

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
